// File: rtl/rr_mux_select.sv
// Round-robin select sequencer for a 4:1 data mux: grants one of four requesters,
// holds the registered select for the transfer and forces release after MAX_HOLD cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no grant held; evaluate requests in rotating priority
// ST_BUSY | grant held; select frozen, watch DONE / withdrawal / timeout
module rr_mux_select #(
    parameter int MAX_HOLD = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [1:0] o_s,
    output logic [3:0] o_gnt,
    output logic       o_valid,
    output logic       o_timeout
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HCNT_TC = HW'(MAX_HOLD - 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    r_state;
    logic [1:0]    r_last;
    logic [1:0]    r_s;
    logic [3:0]    r_gnt;
    logic          r_valid;
    logic          r_timeout;
    logic [HW-1:0] r_hcnt;

    logic [1:0]    w_pick;
    logic          w_any;
    logic          w_rel_done;
    logic          w_rel_wd;
    logic          w_rel_to;
    logic          w_release;
    logic          w_timeout;

    // Scan from farthest to nearest so the first set bit after r_last wins.
    always_comb begin
        w_pick = r_last;
        for (int k = 4; k >= 1; k--) begin
            if (i_req[r_last + 2'(k)]) begin
                w_pick = r_last + 2'(k);
            end
        end
    end

    assign w_any      = |i_req;
    assign w_rel_done = i_done;
    assign w_rel_wd   = ~i_req[r_s];
    assign w_rel_to   = (r_hcnt == HCNT_TC);
    assign w_release  = w_rel_done | w_rel_wd | w_rel_to;
    assign w_timeout  = w_rel_to & ~w_rel_done & ~w_rel_wd;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_last    <= 2'b11;
            r_s       <= 2'b00;
            r_gnt     <= 4'b0000;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_hcnt    <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_en && w_any) begin
                        r_s     <= w_pick;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_valid <= 1'b1;
                        r_hcnt  <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_release) begin
                        r_last    <= r_s;
                        r_gnt     <= 4'b0000;
                        r_valid   <= 1'b0;
                        r_timeout <= w_timeout;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_hcnt <= r_hcnt + HW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_s       = r_s;
    assign o_gnt     = r_gnt;
    assign o_valid   = r_valid;
    assign o_timeout = r_timeout;

endmodule

// File: doc/rr_mux_select.md
# rr_mux_select

Round-robin select sequencer that sits directly upstream of the 4:1 data multiplexer and drives its 2-bit select. It arbitrates among four requesting sources, holds the granted select stable for the length of a transfer, and forces release on a hold timeout so no source can starve the others. Outputs are registered, so the downstream mux sees a glitch-free select.

## Interface
- MAX_HOLD, default 8: maximum cycles a grant may be held before forced release; legal range 2..256.
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  arbitration enable; low blocks new grants only.
- REQ  input  4  request per source; bit i maps to mux input i (0=A, 1=B, 2=C, 3=D).
- DONE  input  1  end-of-transfer from the granted source; sampled only in BUSY.
- S  output  2  registered select to the mux.
- GNT  output  4  registered one-hot grant; GNT[S] set while VALID.
- VALID  output  1  high while a grant is held; mux output meaningful.
- TIMEOUT  output  1  one-cycle pulse when a grant ends by MAX_HOLD expiry.

## Operation
- Reset values: S=2'b00, GNT=4'b0000, VALID=0, TIMEOUT=0. Internal LAST=2'b11, so source 0 has highest priority first. Hold counter HCNT=0. State IDLE.
- Two states: IDLE, BUSY.
- IDLE: if EN=1 and REQ!=0, select the first set REQ bit searching LAST+1, LAST+2, LAST+3, LAST (mod 4). Load S with that index, GNT with its one-hot, set VALID=1, clear HCNT, go BUSY. Otherwise stay IDLE; S holds its previous value.
- BUSY: S and GNT frozen. HCNT increments each cycle, width clog2(MAX_HOLD), no wrap, because release occurs first.
- Release conditions, checked each BUSY cycle, in priority order:
  - DONE=1.
  - REQ[S]=0, meaning the requester withdrew.
  - HCNT==MAX_HOLD-1, which is a timeout.
- On release: LAST<=S, VALID<=0, GNT<=0, go IDLE. TIMEOUT<=1 only when the timeout condition is the cause. DONE or a withdrawal in the same cycle as expiry suppresses TIMEOUT. S keeps the released index.
- EN falling during BUSY does not abort the grant. The grant completes normally.
- REQ changes on non-granted bits during BUSY are ignored until the next IDLE evaluation.
- RST asserted at any point, including mid-grant, returns all registers to reset values on that edge. There is no release pulse and TIMEOUT=0.

## Timing
- Grant latency: REQ/EN sampled at edge k in IDLE. S, GNT and VALID update at edge k, so they are visible in cycle k+1.
- Release latency: the release condition sampled at edge m. VALID=0 and TIMEOUT pulse are visible in cycle m+1. TIMEOUT drops at edge m+1.
- A minimum of one IDLE cycle separates consecutive grants. The back-to-back grant period is at least (hold cycles + 1).
- Maximum grant length is MAX_HOLD cycles with VALID=1. With MAX_HOLD=8 and REQ held and no DONE, VALID is high for exactly 8 cycles.
- Worst-case wait for a continuously requesting source is 3×(MAX_HOLD+1) cycles.
- Outputs depend only on registers. There is no combinational path from inputs to outputs.

## Test plan
- Reset: drive RST=1 for 2 cycles with REQ=4'b1111 → S=00, GNT=0000, VALID=0, TIMEOUT=0. First grant after RST=0, EN=1 goes to source 0 one cycle later.
- Rotation: REQ=4'b1111, pulse DONE 3 cycles into each grant → grant order 0,1,2,3,0. Each grant lasts 3 VALID cycles with a 1-cycle gap.
- Timeout: MAX_HOLD=8, REQ=4'b0100, DONE=0 → S=10, VALID high exactly 8 cycles, then TIMEOUT=1 for 1 cycle. Source 2 is regranted after the idle cycle.
- Simultaneous events: DONE=1 in the same cycle HCNT==MAX_HOLD-1 → release occurs and TIMEOUT stays 0. In a separate run, REQ[S] drops mid-grant → release next edge and TIMEOUT=0.
- EN gating: EN=0 with REQ=4'b0010 → VALID stays 0. EN=0 asserted mid-grant → grant runs to DONE, then no new grant until EN=1.
- Mid-grant reset: RST=1 while BUSY on source 3 → next cycle S=00, GNT=0000, VALID=0. After release with REQ=4'b1001, source 0 is granted first because LAST=3.
